// File: rtl/rr_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_sched_pkg : shared constants, types and helpers for the round-robin mux
// scheduler. Revision 1.0
// ----------------------------------------------------------------------------
package rr_sched_pkg;

   localparam int NUM_REQ_DEF = 8;
   localparam int DATA_W_DEF  = 8;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   localparam int SEL_W_DEF = clog2(NUM_REQ_DEF);

   typedef logic [SEL_W_DEF-1:0] sel_t;

   // The output register is either empty or holding one word; out_valid is the state bit.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_priority_pick : first set bit of elig searched upward from ptr, wrapping.
// Revision 1.0
// ----------------------------------------------------------------------------
module rr_priority_pick
   import rr_sched_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   localparam int SEL_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] elig,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   pick,
   output logic               any_elig
);

   logic [NUM_REQ-1:0] w_rot;
   logic [SEL_W-1:0]   w_first;
   logic [SEL_W-1:0]   w_idx;

   // Rotate so ptr lands at bit 0; index arithmetic wraps because NUM_REQ is a power of two.
   always_comb begin
      w_rot = '0;
      w_idx = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_idx    = ptr + j[SEL_W-1:0];
         w_rot[j] = elig[w_idx];
      end
   end

   always_comb begin
      w_first = '0;
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_first = j[SEL_W-1:0];
         end
      end
   end

   assign pick     = w_first + ptr;
   assign any_elig = |elig;

endmodule
`default_nettype wire

// File: rtl/rr_mux_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_mux_scheduler : round-robin share of one registered valid/ready lane
// between NUM_REQ requesters. Revision 1.0
// ----------------------------------------------------------------------------
module rr_mux_scheduler
   import rr_sched_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   parameter  int DATA_W  = DATA_W_DEF,
   localparam int SEL_W   = clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        in_valid,
   input  logic [NUM_REQ*DATA_W-1:0] in_data,
   output logic [NUM_REQ-1:0]        in_ready,
   input  logic [NUM_REQ-1:0]        cfg_mask,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready
);

   state_t             state_q;
   logic [DATA_W-1:0]  data_q;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   ptr_q;

   logic [NUM_REQ-1:0] w_elig;
   logic [SEL_W-1:0]   w_pick;
   logic               w_any;
   logic               w_slot_free;
   logic               w_grant;
   logic [DATA_W-1:0]  w_pick_data;

   assign w_elig = in_valid & cfg_mask;

   rr_priority_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .elig     (w_elig),
      .ptr      (ptr_q),
      .pick     (w_pick),
      .any_elig (w_any)
   );

   assign w_slot_free = (state_q == ST_EMPTY) || out_ready;
   // A grant is always a transfer: the picked requester is eligible, hence valid.
   assign w_grant     = w_slot_free && w_any && !rst;

   always_comb begin
      in_ready = '0;
      if (w_grant) begin
         in_ready[w_pick] = 1'b1;
      end
   end

   // Select only the picked slice so unknowns on other requesters never reach the register.
   assign w_pick_data = in_data[w_pick*DATA_W +: DATA_W];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         sel_q   <= '0;
         ptr_q   <= '0;
      end else if (w_grant) begin
         state_q <= ST_FULL;
         data_q  <= w_pick_data;
         sel_q   <= w_pick;
         ptr_q   <= w_pick + SEL_W'(1);
      end else if (out_ready) begin
         state_q <= ST_EMPTY;
      end
   end

   assign out_valid = (state_q == ST_FULL);
   assign out_data  = data_q;
   assign out_sel   = sel_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_rr_mux_scheduler : table-driven check of the round-robin mux scheduler.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_rr_mux_scheduler;

   typedef struct {
      logic [7:0] vld;
      logic [7:0] msk;
      logic       ordy;
      logic [7:0] exp_rdy;
      logic       exp_ov;
      logic [2:0] exp_sel;
      logic [7:0] exp_dat;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [7:0]  in_valid;
   logic [63:0] in_data;
   logic [7:0]  in_ready;
   logic [7:0]  cfg_mask;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [2:0]  out_sel;
   logic        out_ready;

   int n_tests;
   int n_fail;
   vec_t tbl[$];

   rr_mux_scheduler #(
      .NUM_REQ (8),
      .DATA_W  (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .cfg_mask  (cfg_mask),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [7:0] vld, input logic [7:0] msk, input logic ordy,
                               input logic [7:0] exp_rdy, input logic exp_ov, input logic [2:0] exp_sel);
      vec_t v;
      v.vld     = vld;
      v.msk     = msk;
      v.ordy    = ordy;
      v.exp_rdy = exp_rdy;
      v.exp_ov  = exp_ov;
      v.exp_sel = exp_sel;
      v.exp_dat = 8'h10 + {5'd0, exp_sel};
      return v;
   endfunction

   // Each step starts at a falling edge and ends at the next falling edge.
   task automatic apply_row(input vec_t v, input int idx);
      in_valid  = v.vld;
      cfg_mask  = v.msk;
      out_ready = v.ordy;
      #1;
      check($sformatf("row%0d in_ready", idx), {24'd0, in_ready}, {24'd0, v.exp_rdy});
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", idx), {31'd0, out_valid}, {31'd0, v.exp_ov});
      check($sformatf("row%0d out_sel", idx), {29'd0, out_sel}, {29'd0, v.exp_sel});
      check($sformatf("row%0d out_data", idx), {24'd0, out_data}, {24'd0, v.exp_dat});
      @(negedge clk);
   endtask

   initial begin
      int mask_seq[16];
      n_tests = 0;
      n_fail  = 0;
      mask_seq = '{7, 0, 1, 2, 4, 5, 6, 7, 0, 1, 2, 4, 5, 6, 7, 0};

      // Full rotation 0..7,0 with one word per cycle; ends with ptr=1.
      for (int k = 0; k < 9; k++)
         tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'(1 << (k % 8)), 1'b1, 3'(k % 8)));
      // Backpressure: word 0 held, no grants.
      for (int k = 0; k < 5; k++)
         tbl.push_back(mk(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b1, 3'd0));
      tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'h02, 1'b1, 3'd1));
      // Advance ptr to 7.
      for (int k = 2; k < 7; k++)
         tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'(1 << k), 1'b1, 3'(k)));
      // Sparse 2 and 6 starting from ptr=7, wrapping.
      tbl.push_back(mk(8'h44, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2));
      tbl.push_back(mk(8'h44, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6));
      tbl.push_back(mk(8'h44, 8'hFF, 1'b1, 8'h04, 1'b1, 3'd2));
      tbl.push_back(mk(8'h44, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6));
      // Single requester granted back-to-back.
      for (int k = 0; k < 3; k++)
         tbl.push_back(mk(8'h40, 8'hFF, 1'b1, 8'h40, 1'b1, 3'd6));
      // Nothing valid, then everything masked: output drains, sel/data hold.
      tbl.push_back(mk(8'h00, 8'hFF, 1'b1, 8'h00, 1'b0, 3'd6));
      tbl.push_back(mk(8'hFF, 8'h00, 1'b1, 8'h00, 1'b0, 3'd6));
      // Requester 3 masked over 16 transfers from ptr=7.
      for (int k = 0; k < 16; k++)
         tbl.push_back(mk(8'hFF, 8'hF7, 1'b1, 8'(1 << mask_seq[k]), 1'b1, 3'(mask_seq[k])));
      // Re-enable from ptr=1: 3 comes up on the third transfer.
      for (int k = 1; k < 4; k++)
         tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 8'(1 << k), 1'b1, 3'(k)));
      // Stall while masking everything: held word unaffected.
      tbl.push_back(mk(8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 3'd3));

      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'h10 + 8'(i);
      rst       = 1'b1;
      in_valid  = 8'hFF;
      cfg_mask  = 8'hFF;
      out_ready = 1'b1;

      // Reset held 3 cycles with all requesters valid.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         check("rst out_valid", {31'd0, out_valid}, 32'd0);
         check("rst out_data", {24'd0, out_data}, 32'd0);
         check("rst out_sel", {29'd0, out_sel}, 32'd0);
         check("rst in_ready", {24'd0, in_ready}, 32'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-rst in_ready", {24'd0, in_ready}, 32'h01);

      foreach (tbl[i]) apply_row(tbl[i], i);

      // Mid-operation reset: stalled word discarded, ptr back to 0.
      rst       = 1'b1;
      in_valid  = 8'hFF;
      cfg_mask  = 8'hFF;
      out_ready = 1'b1;
      #1;
      check("midrst in_ready", {24'd0, in_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("midrst out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst out_sel", {29'd0, out_sel}, 32'd0);
      check("midrst out_data", {24'd0, out_data}, 32'd0);
      @(negedge clk);
      rst              = 1'b0;
      in_valid         = 8'h30;
      in_data[5*8 +: 8] = 8'hxx;
      #1;
      check("after-rst in_ready", {24'd0, in_ready}, 32'h10);
      @(posedge clk);
      #1;
      check("after-rst out_valid", {31'd0, out_valid}, 32'd1);
      check("after-rst out_sel", {29'd0, out_sel}, 32'd4);
      check("after-rst out_data", {24'd0, out_data}, 32'h14);
      @(negedge clk);
      in_valid = 8'h30;
      #1;
      check("next in_ready", {24'd0, in_ready}, 32'h20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
